// File: rtl/icache.sv
// Direct-mapped instruction cache: zero-latency hits and line refill in WORDS
// beats from a single-cycle-ready main memory port.
module icache #(
  parameter int DATA_WIDTH = 32,
  parameter int SETS       = 16,
  parameter int WORDS      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] RD,
  output logic                  hit,
  output logic                  stall,
  output logic                  mem_req,
  output logic [DATA_WIDTH-1:0] mem_addr,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int OFF_W  = $clog2(WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = DATA_WIDTH - 2 - OFF_W - IDX_W;
  localparam int LINE_W = TAG_W + IDX_W;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] REFILL = 1'b1;

  logic [0:0]            state;
  logic [SETS-1:0]       valid;
  logic [TAG_W-1:0]      tag_mem  [SETS];
  logic [DATA_WIDTH-1:0] data_mem [SETS*WORDS];
  logic [OFF_W-1:0]      counter;
  logic [LINE_W-1:0]     line;   // tag and index of the line being refilled

  logic [OFF_W-1:0] a_off;
  logic [IDX_W-1:0] a_idx, l_idx;
  logic [TAG_W-1:0] a_tag, l_tag;
  logic             last_beat, beat;
  logic             unused_a;

  assign a_off     = A[2 +: OFF_W];
  assign a_idx     = A[2+OFF_W +: IDX_W];
  assign a_tag     = A[DATA_WIDTH-1 -: TAG_W];
  assign l_idx     = line[IDX_W-1:0];
  assign l_tag     = line[LINE_W-1 -: TAG_W];
  assign unused_a  = ^A[1:0];
  assign last_beat = (counter == OFF_W'(WORDS - 1));
  assign beat      = (state == REFILL) && mem_ready && !flush;

  assign hit      = req && (state == IDLE) && !flush && valid[a_idx] && (tag_mem[a_idx] == a_tag);
  assign stall    = req && !hit && !reset;
  assign RD       = data_mem[{a_idx, a_off}];
  assign mem_req  = (state == REFILL);
  assign mem_addr = mem_req ? {line, counter, 2'b00} : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      valid   <= '0;
      counter <= '0;
      line    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            valid <= '0;
          end else if (req && !hit) begin
            state   <= REFILL;
            line    <= A[DATA_WIDTH-1 -: LINE_W];
            counter <= '0;
          end
        end
        REFILL: begin
          // A flush abandons the refill; the line never becomes valid.
          if (flush) begin
            valid   <= '0;
            state   <= IDLE;
            counter <= '0;
          end else if (mem_ready) begin
            counter <= counter + OFF_W'(1);
            if (last_beat) begin
              valid[l_idx] <= 1'b1;
              state        <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: tag and data arrays are deliberately left without reset; the valid
  // bits alone decide whether their contents are meaningful.
  always_ff @(posedge clk) begin
    if (beat) begin
      data_mem[{l_idx, counter}] <= mem_rdata;
      if (last_beat) tag_mem[l_idx] <= l_tag;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed vector table for the refill,
// eviction, backpressure, flush and reset corners, then a random run vs a model.
module tb_icache;
  localparam int DW    = 32;
  localparam int SETS  = 16;
  localparam int WORDS = 4;

  logic          clk = 1'b0;
  logic          reset, req, flush, mem_ready;
  logic [DW-1:0] A, RD, mem_addr, mem_rdata, rnd_rdata;
  logic          hit, stall, mem_req;
  bit            use_f;
  int            n_cmp = 0;
  int            n_bad = 0;

  always #5 clk = ~clk;

  icache #(.DATA_WIDTH(DW), .SETS(SETS), .WORDS(WORDS)) dut (
    .clk(clk), .reset(reset), .req(req), .A(A), .flush(flush),
    .RD(RD), .hit(hit), .stall(stall),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  // Memory contents: a distinct word for every word-aligned address.
  function automatic logic [DW-1:0] f(input logic [DW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  assign mem_rdata = use_f ? f(mem_addr) : rnd_rdata;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic rq, input logic [DW-1:0] a, input logic fl,
                       input logic rdy, input logic [DW-1:0] rdata);
    @(negedge clk);
    req = rq; A = a; flush = fl; mem_ready = rdy; rnd_rdata = rdata;
    #2;
  endtask

  typedef struct {
    logic          rq;
    logic [DW-1:0] a;
    logic          fl, rdy, h, st, mr;
    logic [DW-1:0] ma, rd;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic rq, input logic [DW-1:0] a, input logic fl, input logic rdy,
                     input logic h, input logic st, input logic mr,
                     input logic [DW-1:0] ma, input logic [DW-1:0] rd_addr);
    vec_t v;
    v.rq = rq; v.a = a; v.fl = fl; v.rdy = rdy;
    v.h = h; v.st = st; v.mr = mr; v.ma = ma; v.rd = f(rd_addr);
    tbl.push_back(v);
  endtask

  // Reference model: line contents plus the queue of beat addresses still owed.
  bit            m_valid [SETS];
  logic [23:0]   m_tag   [SETS];
  logic [DW-1:0] m_data  [SETS][WORDS];
  logic [DW-1:0] m_buf   [WORDS];
  logic [DW-1:0] m_q[$];
  bit            m_ref;
  int            m_lidx;
  logic [23:0]   m_ltag;

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) m_valid[s] = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req = 1'b1; A = 32'h104; flush = 1'b0; mem_ready = 1'b1;
    rnd_rdata = '0; use_f = 1'b1;
    #3;
    check("reset.hit", hit, 0);
    check("reset.stall", stall, 0);
    check("reset.mem_req", mem_req, 0);
    check("reset.mem_addr", mem_addr, 0);
    req = 1'b0;
    #5 reset = 1'b0;

    // Cold miss, then line reuse
    add(1, 'h104, 0, 1, 0, 1, 0, 'h000, 0);
    add(1, 'h104, 0, 1, 0, 1, 1, 'h100, 0);
    add(1, 'h104, 0, 1, 0, 1, 1, 'h104, 0);
    add(1, 'h104, 0, 1, 0, 1, 1, 'h108, 0);
    add(1, 'h104, 0, 1, 0, 1, 1, 'h10C, 0);
    add(1, 'h104, 0, 1, 1, 0, 0, 'h000, 'h104);
    add(1, 'h100, 0, 1, 1, 0, 0, 'h000, 'h100);
    add(1, 'h108, 0, 0, 1, 0, 0, 'h000, 'h108);
    add(1, 'h10F, 0, 0, 1, 0, 0, 'h000, 'h10C);
    add(0, 'h200, 0, 1, 0, 0, 0, 'h000, 0);
    add(0, 'h100, 0, 1, 0, 0, 0, 'h000, 0);
    // Conflict eviction; A wanders during the refill
    add(1, 'h500, 0, 1, 0, 1, 0, 'h000, 0);
    add(1, 'h100, 0, 1, 0, 1, 1, 'h500, 0);
    add(1, 'h104, 0, 1, 0, 1, 1, 'h504, 0);
    add(1, 'h7FC, 0, 1, 0, 1, 1, 'h508, 0);
    add(1, 'h500, 0, 1, 0, 1, 1, 'h50C, 0);
    add(1, 'h508, 0, 1, 1, 0, 0, 'h000, 'h508);
    add(1, 'h100, 0, 1, 0, 1, 0, 'h000, 0);
    add(1, 'h100, 0, 1, 0, 1, 1, 'h100, 0);
    add(1, 'h100, 0, 1, 0, 1, 1, 'h104, 0);
    add(1, 'h100, 0, 1, 0, 1, 1, 'h108, 0);
    add(1, 'h100, 0, 1, 0, 1, 1, 'h10C, 0);
    add(1, 'h100, 0, 1, 1, 0, 0, 'h000, 'h100);
    // Backpressure: ready pattern 1,0,0,1,1,0,1
    add(1, 'h2A8, 0, 0, 0, 1, 0, 'h000, 0);
    add(1, 'h2A8, 0, 1, 0, 1, 1, 'h2A0, 0);
    add(1, 'h2A8, 0, 0, 0, 1, 1, 'h2A4, 0);
    add(1, 'h2A8, 0, 0, 0, 1, 1, 'h2A4, 0);
    add(1, 'h2A8, 0, 1, 0, 1, 1, 'h2A4, 0);
    add(1, 'h2A8, 0, 1, 0, 1, 1, 'h2A8, 0);
    add(1, 'h2A8, 0, 0, 0, 1, 1, 'h2AC, 0);
    add(1, 'h2A8, 0, 1, 0, 1, 1, 'h2AC, 0);
    add(1, 'h2A8, 0, 1, 1, 0, 0, 'h000, 'h2A8);
    add(1, 'h2A0, 0, 0, 1, 0, 0, 'h000, 'h2A0);
    add(1, 'h2A4, 0, 0, 1, 0, 0, 'h000, 'h2A4);
    add(1, 'h2AC, 0, 0, 1, 0, 0, 'h000, 'h2AC);
    add(1, 'h104, 0, 0, 1, 0, 0, 'h000, 'h104);
    // Flush on the second beat of a refill
    add(1, 'h340, 0, 1, 0, 1, 0, 'h000, 0);
    add(1, 'h340, 0, 1, 0, 1, 1, 'h340, 0);
    add(1, 'h340, 1, 1, 0, 1, 1, 'h344, 0);
    add(0, 'h100, 0, 1, 0, 0, 0, 'h000, 0);
    add(1, 'h100, 0, 0, 0, 1, 0, 'h000, 0);
    add(1, 'h100, 1, 0, 0, 1, 1, 'h100, 0);
    add(1, 'h2A8, 0, 1, 0, 1, 0, 'h000, 0);
    add(1, 'h2A8, 0, 1, 0, 1, 1, 'h2A0, 0);
    add(1, 'h2A8, 0, 1, 0, 1, 1, 'h2A4, 0);
    add(1, 'h2A8, 0, 1, 0, 1, 1, 'h2A8, 0);
    add(1, 'h2A8, 0, 1, 0, 1, 1, 'h2AC, 0);
    add(1, 'h2A8, 0, 1, 1, 0, 0, 'h000, 'h2A8);
    // Flush in IDLE: no hit that cycle, no refill, line gone afterwards
    add(1, 'h2A8, 1, 1, 0, 1, 0, 'h000, 0);
    add(1, 'h2A8, 0, 1, 0, 1, 0, 'h000, 0);
    add(1, 'h2A8, 0, 1, 0, 1, 1, 'h2A0, 0);
    add(1, 'h2A8, 0, 1, 0, 1, 1, 'h2A4, 0);
    add(1, 'h2A8, 0, 1, 0, 1, 1, 'h2A8, 0);
    add(1, 'h2A8, 0, 1, 0, 1, 1, 'h2AC, 0);
    add(1, 'h2A8, 0, 1, 1, 0, 0, 'h000, 'h2A8);
    add(1, 'h100, 0, 1, 0, 1, 0, 'h000, 0);
    add(1, 'h100, 0, 1, 0, 1, 1, 'h100, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].rq, tbl[i].a, tbl[i].fl, tbl[i].rdy, '0);
      check($sformatf("v%0d.hit", i), hit, tbl[i].h);
      check($sformatf("v%0d.stall", i), stall, tbl[i].st);
      check($sformatf("v%0d.mem_req", i), mem_req, tbl[i].mr);
      check($sformatf("v%0d.mem_addr", i), mem_addr, tbl[i].ma);
      if (tbl[i].h) check($sformatf("v%0d.rd", i), RD, tbl[i].rd);
    end

    // Asynchronous reset between edges, mid-refill
    drive(1, 'h100, 0, 1, '0);
    check("rst.pre_addr", mem_addr, 'h104);
    #1 reset = 1'b1;
    #1;
    check("rst.mem_req", mem_req, 0);
    check("rst.mem_addr", mem_addr, 0);
    check("rst.hit", hit, 0);
    check("rst.stall", stall, 0);
    @(negedge clk);
    req = 1'b0;
    reset = 1'b0;
    drive(1, 'h100, 0, 1, '0);
    check("rst.remiss_hit", hit, 0);
    check("rst.remiss_stall", stall, 1);
    drive(1, 'h100, 0, 1, '0);
    check("rst.refill_addr", mem_addr, 'h100);
    check("rst.refill_req", mem_req, 1);

    // Random run against the model
    @(negedge clk);
    req = 1'b0; flush = 1'b0; reset = 1'b1;
    #2 reset = 1'b0;
    use_f = 1'b0;
    model_clear();
    m_ref = 1'b0;
    m_q.delete();
    for (int c = 0; c < 3000; c++) begin
      logic          rq, fl, rdy, eh;
      logic [DW-1:0] a, rdat;
      int            idx, off;
      rq   = ($urandom % 5) != 0;
      fl   = ($urandom % 40) == 0;
      rdy  = ($urandom % 3) != 0;
      rdat = $urandom;
      a    = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 4) | ($urandom % 16);
      if ($urandom % 4 == 0) a = a | 32'h8000_0000;
      drive(rq, a, fl, rdy, rdat);
      idx = int'(a[7:4]);
      off = int'(a[3:2]);
      eh  = rq && !m_ref && !fl && m_valid[idx] && (m_tag[idx] == a[31:8]);
      check("rnd.hit", hit, eh);
      check("rnd.stall", stall, rq && !eh);
      check("rnd.mem_req", mem_req, m_ref);
      check("rnd.mem_addr", mem_addr, m_ref ? m_q[0] : '0);
      if (eh) check("rnd.rd", RD, m_data[idx][off]);
      // Effect of the coming clock edge
      if (!m_ref) begin
        if (fl) model_clear();
        else if (rq && !eh) begin
          m_ref  = 1'b1;
          m_lidx = idx;
          m_ltag = a[31:8];
          m_q.delete();
          for (int k = 0; k < WORDS; k++) m_q.push_back({a[31:4], 4'h0} + 32'(4 * k));
        end
      end else if (fl) begin
        model_clear();
        m_ref = 1'b0;
        m_q.delete();
      end else if (rdy) begin
        m_buf[WORDS - m_q.size()] = rdat;
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          m_valid[m_lidx] = 1'b1;
          m_tag[m_lidx]   = m_ltag;
          for (int k = 0; k < WORDS; k++) m_data[m_lidx][k] = m_buf[k];
          m_ref = 1'b0;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
